hgame_input_cond: RTL

Front-end conditioner for the three-player hand game FSM. It takes raw, asynchronous, bouncing push-button levels A_BTN/B_BTN/C_BTN and produces clean single-cycle press vectors on A/B/C, which connect directly to the game FSM inputs. Presses that arrive close together are merged into one vector, so the game sees genuine simultaneous presses (e.g. 3'b011). After each vector the block holds off new presses so the game's one-cycle winner state cannot swallow one.

---
 rtl/hgame_pkg.sv | 17 +
 rtl/hgame_debounce.sv | 49 ++++
 rtl/hgame_input_cond.sv | 118 +++++++++++
 3 files changed

// File: rtl/hgame_pkg.sv
// Shared constants for the hand-game input conditioner: player bit positions
// in the {A,B,C} vector and the press-combiner state encoding.
package hgame_pkg;

  localparam int P_A = 2;
  localparam int P_B = 1;
  localparam int P_C = 0;
  localparam int N_PLAYERS = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2,
    HOLD    = 2'd3
  } comb_state_t;

endpackage

// File: rtl/hgame_debounce.sv
// One button channel: two-flop synchronizer, stability-count debounce and a
// registered one-cycle press pulse on each accepted rising level.
module hgame_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        // This sample completes the run of differing samples: accept it.
        level_reg <= sync2_reg;
        press_reg <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/hgame_input_cond.sv
// Conditions three raw push-buttons into clean single-cycle {A,B,C} press
// vectors, merging near-simultaneous presses and enforcing a holdoff after each.
module hgame_input_cond
  import hgame_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int WIN       = 3,
  parameter int HOLDOFF   = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic A_BTN,
  input  logic B_BTN,
  input  logic C_BTN,
  output logic A,
  output logic B,
  output logic C,
  output logic BUSY,
  output logic DROPPED
);

  localparam int CNT_MAX = (WIN > HOLDOFF) ? WIN : HOLDOFF;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] WIN_LAST  = CW'(WIN - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF - 1);

  logic [N_PLAYERS-1:0] raw;
  logic [N_PLAYERS-1:0] level;
  logic [N_PLAYERS-1:0] press;
  logic [N_PLAYERS-1:0] events;

  assign raw[P_A] = A_BTN;
  assign raw[P_B] = B_BTN;
  assign raw[P_C] = C_BTN;

  generate
    for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_chan
      hgame_debounce #(
        .DB_CYCLES(DB_CYCLES)
      ) u_debounce (
        .CLK  (CLK),
        .RST  (RST),
        .raw  (raw[gi]),
        .level(level[gi]),
        .press(press[gi])
      );
      // A press is only ever issued together with a freshly raised level.
      assign events[gi] = press[gi] & level[gi];
    end
  endgenerate

  comb_state_t          state_reg;
  logic [N_PLAYERS-1:0] vec_reg;
  logic [N_PLAYERS-1:0] pulse_reg;
  logic [CW-1:0]        cnt_reg;
  logic                 busy_reg;
  logic                 dropped_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg   <= IDLE;
      vec_reg     <= '0;
      pulse_reg   <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      dropped_reg <= 1'b0;
    end else begin
      pulse_reg   <= '0;
      dropped_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|events) begin
            vec_reg   <= events;
            cnt_reg   <= WIN_LAST;
            state_reg <= COLLECT;
            busy_reg  <= 1'b1;
          end
        end
        COLLECT: begin
          vec_reg <= vec_reg | events;
          if (cnt_reg == '0) begin
            state_reg <= EMIT;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        EMIT: begin
          pulse_reg   <= vec_reg;
          vec_reg     <= '0;
          cnt_reg     <= HOLD_LAST;
          state_reg   <= HOLD;
          dropped_reg <= |events;
        end
        HOLD: begin
          // Lockout keeps the game's one-cycle winner state from eating a press.
          dropped_reg <= |events;
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign A       = pulse_reg[P_A];
  assign B       = pulse_reg[P_B];
  assign C       = pulse_reg[P_C];
  assign BUSY    = busy_reg;
  assign DROPPED = dropped_reg;

endmodule
